// File: rtl/boot_overlay_ctrl.sv
// Boot ROM overlay controller: maps the boot pROM over one 256-byte CPU window
// until software disables it, forwards all other accesses to the external bus.
module boot_overlay_ctrl #(
  parameter logic [15:0] BOOT_DIS_ADDR = 16'hFF50,
  parameter logic [7:0]  OVL_HI        = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        rom_ce,
  output logic        rom_oce,
  output logic        rom_reset,
  output logic [7:0]  rom_ad,
  input  logic [7:0]  rom_dout,
  input  logic        dbg_req,
  input  logic [7:0]  dbg_addr,
  output logic [7:0]  dbg_rdata,
  output logic        dbg_valid,
  output logic        boot_active
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROM_RD = 2'd1;
  localparam logic [1:0] EXT    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0] state;
  logic       dbg_txn;
  logic       ext_rd;
  logic       cpu_req;
  logic       ovl_hit;
  logic       boot_dis_wr;

  assign rom_oce   = 1'b1;
  assign rom_reset = reset;

  // A simultaneous rd+wr is a write, and writes never reach the ROM.
  assign cpu_req     = cpu_rd | cpu_wr;
  assign ovl_hit     = cpu_rd & ~cpu_wr & boot_active & (cpu_addr[15:8] == OVL_HI);
  assign boot_dis_wr = cpu_wr & (cpu_addr == BOOT_DIS_ADDR) & cpu_wdata[0];

  // The pROM is addressed combinationally in the issuing IDLE cycle so its
  // one-cycle latency lands the byte in ROM_RD.
  always_comb begin
    rom_ce = 1'b0;
    rom_ad = cpu_addr[7:0];
    if ((state == IDLE) && !reset) begin
      if (ovl_hit) begin
        rom_ce = 1'b1;
      end else if (!cpu_req && dbg_req) begin
        rom_ce = 1'b1;
        rom_ad = dbg_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      boot_active <= 1'b1;
      cpu_ready   <= 1'b0;
      dbg_valid   <= 1'b0;
      ext_req     <= 1'b0;
      ext_we      <= 1'b0;
      cpu_rdata   <= 8'h00;
      dbg_rdata   <= 8'h00;
      ext_addr    <= 16'h0000;
      ext_wdata   <= 8'h00;
      dbg_txn     <= 1'b0;
      ext_rd      <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      dbg_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ovl_hit) begin
            dbg_txn <= 1'b0;
            state   <= ROM_RD;
          end else if (cpu_req) begin
            ext_req   <= 1'b1;
            ext_we    <= cpu_wr;
            ext_addr  <= cpu_addr;
            ext_wdata <= cpu_wdata;
            ext_rd    <= ~cpu_wr;
            dbg_txn   <= 1'b0;
            state     <= EXT;
            // The overlay can only be switched off, never back on, until reset.
            if (boot_dis_wr) begin
              boot_active <= 1'b0;
            end
          end else if (dbg_req) begin
            dbg_txn <= 1'b1;
            state   <= ROM_RD;
          end
        end
        ROM_RD: begin
          if (dbg_txn) begin
            dbg_rdata <= rom_dout;
            dbg_valid <= 1'b1;
          end else begin
            cpu_rdata <= rom_dout;
            cpu_ready <= 1'b1;
          end
          state <= DONE;
        end
        EXT: begin
          if (ext_ack) begin
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            cpu_ready <= 1'b1;
            if (ext_rd) begin
              cpu_rdata <= ext_rdata;
            end
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_overlay_ctrl.sv
// Directed bench for boot_overlay_ctrl: overlay reads, boot disable, external
// bus forwarding, debug arbitration, reset abort and back-to-back reads.
module tb_boot_overlay_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
  logic        rom_ce, rom_oce, rom_reset;
  logic [7:0]  rom_ad;
  logic [7:0]  rom_dout;
  logic        dbg_req;
  logic [7:0]  dbg_addr;
  logic [7:0]  dbg_rdata;
  logic        dbg_valid;
  logic        boot_active;

  logic [7:0]  rom_mem [256];
  int          errs = 0;
  int          checks = 0;

  boot_overlay_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset), .rom_ad(rom_ad),
    .rom_dout(rom_dout),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
    .boot_active(boot_active)
  );

  always #5 clk = ~clk;

  // pROM model: byte at address a is a ^ 8'h06, one-cycle read latency.
  always @(posedge clk) begin
    if (rom_ce) rom_dout <= rom_mem[rom_ad];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic exp_rdy [6];
  logic exp_ce  [6];

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'h06;
    rom_dout = 8'h00;
    reset = 1'b1; cpu_addr = 16'h0000; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
    ext_rdata = 8'h00; ext_ack = 1'b0; dbg_req = 1'b0; dbg_addr = 8'h00;
    exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_ce  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    step(); step();

    // Reset state
    sample();
    chk("rst_boot_active", {15'd0, boot_active}, 16'd1);
    chk("rst_cpu_ready", {15'd0, cpu_ready}, 16'd0);
    chk("rst_ext_req", {15'd0, ext_req}, 16'd0);
    chk("rst_cpu_rdata", {8'd0, cpu_rdata}, 16'h0000);
    chk("rst_ext_addr", ext_addr, 16'h0000);
    chk("rst_rom_ce", {15'd0, rom_ce}, 16'd0);
    chk("rst_rom_reset", {15'd0, rom_reset}, 16'd1);
    chk("rom_oce", {15'd0, rom_oce}, 16'd1);
    step();
    reset = 1'b0;
    step();

    // Overlay read of 0x0000
    cpu_rd = 1'b1; cpu_addr = 16'h0000;
    sample();
    chk("ovl_rom_ce_N", {15'd0, rom_ce}, 16'd1);
    chk("ovl_rom_ad_N", {8'd0, rom_ad}, 16'h0000);
    chk("ovl_rom_reset_low", {15'd0, rom_reset}, 16'd0);
    step(); sample();
    chk("ovl_rom_ce_N1", {15'd0, rom_ce}, 16'd0);
    chk("ovl_ready_N1", {15'd0, cpu_ready}, 16'd0);
    step(); sample();
    chk("ovl_ready_N2", {15'd0, cpu_ready}, 16'd1);
    chk("ovl_rdata_N2", {8'd0, cpu_rdata}, 16'h0006);
    cpu_rd = 1'b0;
    step(); sample();
    chk("ovl_ready_N3", {15'd0, cpu_ready}, 16'd0);

    // Disabling write to FF50, ack three cycles after issue
    step();
    cpu_wr = 1'b1; cpu_addr = 16'hFF50; cpu_wdata = 8'h01;
    sample();
    chk("dis_rom_ce", {15'd0, rom_ce}, 16'd0);
    chk("dis_boot_before", {15'd0, boot_active}, 16'd1);
    step(); sample();
    chk("dis_ext_req", {15'd0, ext_req}, 16'd1);
    chk("dis_ext_we", {15'd0, ext_we}, 16'd1);
    chk("dis_ext_addr", ext_addr, 16'hFF50);
    chk("dis_ext_wdata", {8'd0, ext_wdata}, 16'h0001);
    chk("dis_boot_after", {15'd0, boot_active}, 16'd0);
    step(); sample();
    chk("dis_ext_req_wait", {15'd0, ext_req}, 16'd1);
    chk("dis_ready_wait", {15'd0, cpu_ready}, 16'd0);
    step();
    ext_ack = 1'b1;
    step();
    ext_ack = 1'b0;
    sample();
    chk("dis_ready", {15'd0, cpu_ready}, 16'd1);
    chk("dis_ext_req_drop", {15'd0, ext_req}, 16'd0);
    cpu_wr = 1'b0; cpu_wdata = 8'h00;
    step();

    // Read of 0x0000 after disable goes to ext
    cpu_rd = 1'b1; cpu_addr = 16'h0000;
    sample();
    chk("post_rom_ce", {15'd0, rom_ce}, 16'd0);
    step(); sample();
    chk("post_ext_req", {15'd0, ext_req}, 16'd1);
    chk("post_ext_we", {15'd0, ext_we}, 16'd0);
    chk("post_ext_addr", ext_addr, 16'h0000);
    ext_ack = 1'b1; ext_rdata = 8'hC3;
    step();
    ext_ack = 1'b0;
    sample();
    chk("post_ready", {15'd0, cpu_ready}, 16'd1);
    chk("post_rdata", {8'd0, cpu_rdata}, 16'h00C3);
    chk("post_boot_low", {15'd0, boot_active}, 16'd0);
    cpu_rd = 1'b0;
    step();

    // Reset during EXT aborts the read and restores the overlay
    cpu_rd = 1'b1; cpu_addr = 16'h8000;
    step(); sample();
    chk("abort_ext_req", {15'd0, ext_req}, 16'd1);
    reset = 1'b1;
    step(); sample();
    chk("abort_ext_req_drop", {15'd0, ext_req}, 16'd0);
    chk("abort_no_ready", {15'd0, cpu_ready}, 16'd0);
    chk("abort_boot_active", {15'd0, boot_active}, 16'd1);
    reset = 1'b0; cpu_rd = 1'b0;
    step(); sample();
    chk("abort_no_ready_late", {15'd0, cpu_ready}, 16'd0);
    chk("abort_ext_req_idle", {15'd0, ext_req}, 16'd0);
    step();

    // Non-disabling write to FF50 keeps the overlay
    cpu_wr = 1'b1; cpu_addr = 16'hFF50; cpu_wdata = 8'h00;
    step(); sample();
    chk("nodis_ext_req", {15'd0, ext_req}, 16'd1);
    chk("nodis_boot", {15'd0, boot_active}, 16'd1);
    ext_ack = 1'b1;
    step();
    ext_ack = 1'b0;
    sample();
    chk("nodis_ready", {15'd0, cpu_ready}, 16'd1);
    cpu_wr = 1'b0;
    step();
    cpu_rd = 1'b1; cpu_addr = 16'h00FF;
    sample();
    chk("nodis_rom_ce", {15'd0, rom_ce}, 16'd1);
    chk("nodis_rom_ad", {8'd0, rom_ad}, 16'h00FF);
    step(); step(); sample();
    chk("nodis_rd_ready", {15'd0, cpu_ready}, 16'd1);
    chk("nodis_rd_data", {8'd0, cpu_rdata}, 16'h00F9);
    chk("nodis_boot_still", {15'd0, boot_active}, 16'd1);
    cpu_rd = 1'b0;
    step();

    // CPU wins over debug in the same cycle
    cpu_rd = 1'b1; cpu_addr = 16'h0001; dbg_req = 1'b1; dbg_addr = 8'hFC;
    sample();
    chk("arb_rom_ad_cpu", {8'd0, rom_ad}, 16'h0001);
    chk("arb_rom_ce_cpu", {15'd0, rom_ce}, 16'd1);
    step(); sample();
    chk("arb_dbg_valid_N1", {15'd0, dbg_valid}, 16'd0);
    step(); sample();
    chk("arb_cpu_ready_N2", {15'd0, cpu_ready}, 16'd1);
    chk("arb_cpu_rdata_N2", {8'd0, cpu_rdata}, 16'h0007);
    chk("arb_rom_ce_N2", {15'd0, rom_ce}, 16'd0);
    cpu_rd = 1'b0;
    step(); sample();
    chk("arb_dbg_rom_ce_N3", {15'd0, rom_ce}, 16'd1);
    chk("arb_dbg_rom_ad_N3", {8'd0, rom_ad}, 16'h00FC);
    step(); sample();
    chk("arb_dbg_valid_N4", {15'd0, dbg_valid}, 16'd0);
    dbg_req = 1'b0;
    step(); sample();
    chk("arb_dbg_valid_N5", {15'd0, dbg_valid}, 16'd1);
    chk("arb_dbg_rdata_N5", {8'd0, dbg_rdata}, 16'h00FA);
    chk("arb_no_cpu_ready_N5", {15'd0, cpu_ready}, 16'd0);
    step(); sample();
    chk("arb_dbg_valid_N6", {15'd0, dbg_valid}, 16'd0);
    step();

    // Back-to-back overlay reads with cpu_rd held
    cpu_rd = 1'b1; cpu_addr = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk($sformatf("b2b_ready_%0d", i), {15'd0, cpu_ready}, {15'd0, exp_rdy[i]});
      chk($sformatf("b2b_rom_ce_%0d", i), {15'd0, rom_ce}, {15'd0, exp_ce[i]});
      step();
    end
    chk("b2b_rdata", {8'd0, cpu_rdata}, 16'h0004);
    cpu_rd = 1'b0;
    step();

    // rd+wr together on an overlay address is an external write
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0003; cpu_wdata = 8'h5A;
    sample();
    chk("rw_rom_ce", {15'd0, rom_ce}, 16'd0);
    step(); sample();
    chk("rw_ext_req", {15'd0, ext_req}, 16'd1);
    chk("rw_ext_we", {15'd0, ext_we}, 16'd1);
    chk("rw_ext_addr", ext_addr, 16'h0003);
    chk("rw_ext_wdata", {8'd0, ext_wdata}, 16'h005A);
    ext_ack = 1'b1; ext_rdata = 8'h11;
    step();
    ext_ack = 1'b0;
    sample();
    chk("rw_ready", {15'd0, cpu_ready}, 16'd1);
    chk("rw_rdata_kept", {8'd0, cpu_rdata}, 16'h0004);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
